// File: rtl/var_clock_gen_if.sv
// rtl/var_clock_gen_if.sv - control and output bundle for the multi-channel clock generator
interface var_clock_gen_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*WIDTH-1:0] set_count;
    logic [CHANNELS-1:0]       load;
    logic                      sync;
    logic [CHANNELS-1:0]       outsig;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       pending;

    modport master (
        output en, mode, set_count, load, sync,
        input  outsig, tick, pending
    );

    modport slave (
        input  en, mode, set_count, load, sync,
        output outsig, tick, pending
    );
endinterface

// File: rtl/var_clock_gen.sv
// rtl/var_clock_gen.sv - independent programmable clock dividers with deferred reload and global sync
module var_clock_gen #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    var_clock_gen_if.slave  bus
);
    logic [WIDTH-1:0]    p_cnt [CHANNELS];
    logic [WIDTH-1:0]    q_cnt [CHANNELS];
    logic [WIDTH-1:0]    c_cnt [CHANNELS];
    logic [CHANNELS-1:0] m_mode;
    logic [CHANNELS-1:0] q_mode;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] out_r;
    logic [CHANNELS-1:0] tick_r;

    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] terminal;
    logic [CHANNELS-1:0] apply;

    // A pending value is taken at any boundary: terminal event, sync, or idle edge.
    always_comb begin
        running  = '0;
        terminal = '0;
        apply    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            running[i]  = bus.en[i] && (p_cnt[i] != '0);
            terminal[i] = running[i] && (c_cnt[i] == p_cnt[i] - WIDTH'(1));
            apply[i]    = pend[i] && (terminal[i] || bus.sync || !running[i]);
        end
    end

    // Per-channel counter, reload and output state; sync overrides a coincident terminal event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                p_cnt[i] <= '0;
                q_cnt[i] <= '0;
                c_cnt[i] <= '0;
            end
            m_mode <= '0;
            q_mode <= '0;
            pend   <= '0;
            out_r  <= '0;
            tick_r <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.load[i]) begin
                    q_cnt[i]  <= bus.set_count[i*WIDTH +: WIDTH];
                    q_mode[i] <= bus.mode[i];
                    pend[i]   <= 1'b1;
                end else if (apply[i]) begin
                    pend[i] <= 1'b0;
                end

                if (apply[i]) begin
                    p_cnt[i]  <= q_cnt[i];
                    m_mode[i] <= q_mode[i];
                end

                if (bus.sync || !running[i] || terminal[i]) begin
                    c_cnt[i] <= '0;
                end else begin
                    c_cnt[i] <= c_cnt[i] + WIDTH'(1);
                end

                tick_r[i] <= terminal[i] && !bus.sync;

                if (bus.sync || !running[i]) begin
                    out_r[i] <= 1'b0;
                end else if (terminal[i]) begin
                    out_r[i] <= m_mode[i] ? 1'b1 : ~out_r[i];
                end else if (m_mode[i]) begin
                    out_r[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.outsig  = out_r;
    assign bus.tick    = tick_r;
    assign bus.pending = pend;
endmodule
